serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter. It accepts a parallel word on a valid/ready handshake and drives it onto a single-bit line. Each frame is a start bit, the data bits LSB first, an optional even-parity bit and a stop bit. It is the sending end of the serial link whose receiving side samples the line with plain edge-triggered flip-flops. It sits between a word producer and the off-block serial line.

---
 rtl/serial_tx.sv | 128 ++++++++++++
 tb/tb_serial_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, DATA_W data bits LSB first, optional even parity,
// stop bit, each held CLKS_PER_BIT cycles on a registered, idle-high line.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    input  logic              load,
    output logic              ready,
    output logic              q,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Handshake: a word moves when load && ready are both high at a rising edge;
    // d is sampled only then, and load while ready is low is simply ignored.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] sr_next;
    logic [DATA_W-1:0] sr_shift;
    logic              par;
    logic              par_next;
    logic              q_next;
    logic              done_next;
    logic              bit_end;
    logic              last_bit;
    logic              accept;

    assign bit_end  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit = (idx == IDX_W'(DATA_W - 1));
    assign sr_shift = sr >> 1;
    assign accept   = load && ready;

    // The final stop-bit cycle also accepts, so a new start bit can abut the
    // previous stop bit with no idle gap.
    assign ready = !rst && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            q     <= 1'b1;
            done  <= 1'b0;
            cnt   <= '0;
            idx   <= '0;
            sr    <= '0;
            par   <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            done  <= done_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            sr    <= sr_next;
            par   <= par_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_START;
            S_START:  if (bit_end) state_next = S_DATA;
            S_DATA: begin
                if (bit_end && last_bit) begin
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (bit_end) state_next = S_STOP;
            S_STOP: begin
                if (bit_end) state_next = accept ? S_START : S_IDLE;
            end
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sr_next   = sr;
        par_next  = par;
        idx_next  = idx;
        cnt_next  = cnt;
        done_next = (state == S_STOP) && bit_end;

        if (accept) begin
            sr_next  = d;
            par_next = ^d;
            idx_next = '0;
            cnt_next = '0;
        end else if (state != S_IDLE) begin
            if (bit_end) begin
                cnt_next = '0;
                if ((state == S_DATA) && !last_bit) begin
                    sr_next  = sr_shift;
                    idx_next = idx + IDX_W'(1);
                end
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end

        // Line level follows the state being entered, so q changes on the same
        // edge as the state and stays registered.
        case (state_next)
            S_START:  q_next = 1'b0;
            S_DATA:   q_next = sr_next[0];
            S_PARITY: q_next = par;
            default:  q_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: default configuration plus a DATA_W=5, CLKS_PER_BIT=1,
// no-parity instance, both compared against a per-cycle line model.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d;
    logic       load;
    logic       ready, q, done;
    logic [4:0] d5;
    logic       load5;
    logic       ready5, q5, done5;

    int checks   = 0;
    int failures = 0;

    // Expected line level per cycle after the accepting edge, and cycle indices
    // where done must be high.
    logic exp_q[$];
    int   done_at[$];

    always #5 clk = ~clk;

    serial_tx dut (
        .clk(clk), .rst(rst), .d(d), .load(load),
        .ready(ready), .q(q), .done(done)
    );

    serial_tx #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut5 (
        .clk(clk), .rst(rst), .d(d5), .load(load5),
        .ready(ready5), .q(q5), .done(done5)
    );

    function automatic void push_frame(input logic [7:0] word, input int w,
                                       input int c, input int p);
        logic bits[$];
        int   ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(word[i]);
            ones += int'(word[i]);
        end
        if (p != 0) bits.push_back((ones % 2) == 1);
        bits.push_back(1'b1);
        foreach (bits[i]) repeat (c) exp_q.push_back(bits[i]);
        done_at.push_back(exp_q.size());
    endfunction

    function automatic logic exp_done(input int k);
        foreach (done_at[i]) if (done_at[i] == k) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_line(input int k);
        return (k < exp_q.size()) ? exp_q[k] : 1'b1;
    endfunction

    task automatic wait_ready();
        int waited = 0;
        while (!ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ready !== 1'b1) begin
            $display("FAIL ready_wait: ready=%b required 1 within 100 cycles", ready);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; d = 8'hFF; load5 = 1'b1; d5 = 5'h1F;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({q, done, ready, q5, ready5} !== 5'b10010) begin
                $display("FAIL reset_hold cyc %0d: q,done,ready,q5,ready5=%b required 10010",
                         k, {q, done, ready, q5, ready5});
                failures++;
            end
        end
        rst = 1'b0; load = 1'b0; load5 = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, ready5, q} !== 3'b111) begin
            $display("FAIL reset_release: ready,ready5,q=%b required 111", {ready, ready5, q});
            failures++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({q, done, q5, done5} !== 4'b1010) begin
                $display("FAIL reset_no_frame cyc %0d: q,done,q5,done5=%b required 1010",
                         k, {q, done, q5, done5});
                failures++;
            end
        end
    endtask

    task automatic test_frame(input logic [7:0] word);
        int n = 44;
        int pulses = 0;
        wait_ready();
        exp_q.delete(); done_at.delete();
        push_frame(word, 8, 4, 1);
        d = word; load = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n + 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                load = 1'b0;
                d = 8'($urandom_range(0, 255));
            end
            pulses += int'(done);
            checks++;
            if (q !== exp_line(k) || done !== exp_done(k)) begin
                $display("FAIL frame_%h cyc %0d: q=%b done=%b required q=%b done=%b",
                         word, k, q, done, exp_line(k), exp_done(k));
                failures++;
            end
            if (k < n - 1 || k >= n) begin
                checks++;
                if (ready !== (k >= n)) begin
                    $display("FAIL frame_ready_%h cyc %0d: ready=%b required %b",
                             word, k, ready, (k >= n));
                    failures++;
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            $display("FAIL frame_done_count_%h: pulses=%0d required 1", word, pulses);
            failures++;
        end
    endtask

    task automatic test_load_busy();
        int n = 44;
        int pulses = 0;
        wait_ready();
        exp_q.delete(); done_at.delete();
        push_frame(8'h3C, 8, 4, 1);
        d = 8'h3C; load = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n + 4; k++) begin
            @(negedge clk);
            if (k == 0) load = 1'b0;
            if (k == 4) begin load = 1'b1; d = 8'h00; end
            if (k == 20) load = 1'b0;
            pulses += int'(done);
            checks++;
            if (q !== exp_line(k) || done !== exp_done(k)) begin
                $display("FAIL load_busy cyc %0d: q=%b done=%b required q=%b done=%b",
                         k, q, done, exp_line(k), exp_done(k));
                failures++;
            end
        end
        checks++;
        if (pulses != 1) begin
            $display("FAIL load_busy_done_count: pulses=%0d required 1", pulses);
            failures++;
        end
    endtask

    task automatic test_back_to_back(input logic [7:0] w0, input logic [7:0] w1);
        int n = 44;
        int pulses = 0;
        wait_ready();
        exp_q.delete(); done_at.delete();
        push_frame(w0, 8, 4, 1);
        push_frame(w1, 8, 4, 1);
        d = w0; load = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 2 * n + 3; k++) begin
            @(negedge clk);
            if (k == 0) d = w1;
            if (k == n) load = 1'b0;
            pulses += int'(done);
            checks++;
            if (q !== exp_line(k) || done !== exp_done(k)) begin
                $display("FAIL back_to_back_%h_%h cyc %0d: q=%b done=%b required q=%b done=%b",
                         w0, w1, k, q, done, exp_line(k), exp_done(k));
                failures++;
            end
        end
        checks++;
        if (pulses != 2) begin
            $display("FAIL back_to_back_done_count: pulses=%0d required 2", pulses);
            failures++;
        end
    endtask

    task automatic test_reset_mid_frame();
        wait_ready();
        exp_q.delete(); done_at.delete();
        push_frame(8'hFF, 8, 4, 1);
        d = 8'hFF; load = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (k == 0) load = 1'b0;
            checks++;
            if (k < 10) begin
                if (q !== exp_line(k) || done !== 1'b0) begin
                    $display("FAIL mid_reset_pre cyc %0d: q=%b done=%b required q=%b done=0",
                             k, q, done, exp_line(k));
                    failures++;
                end
            end else if (k == 10) begin
                if ({q, done, ready} !== 3'b100) begin
                    $display("FAIL mid_reset_edge: q,done,ready=%b required 100", {q, done, ready});
                    failures++;
                end
            end else if ({q, done, ready} !== 3'b101) begin
                $display("FAIL mid_reset_after cyc %0d: q,done,ready=%b required 101",
                         k, {q, done, ready});
                failures++;
            end
            if (k == 9) rst = 1'b1;
            if (k == 10) rst = 1'b0;
        end
        test_frame(8'h0F);
    endtask

    task automatic test_small(input logic [4:0] word);
        int n = 7;
        exp_q.delete(); done_at.delete();
        push_frame({3'b000, word}, 5, 1, 0);
        checks++;
        if (ready5 !== 1'b1) begin
            $display("FAIL small_ready_%h: ready5=%b required 1", word, ready5);
            failures++;
        end
        d5 = word; load5 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < n + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin load5 = 1'b0; d5 = 5'($urandom_range(0, 31)); end
            checks++;
            if (q5 !== exp_line(k) || done5 !== exp_done(k)) begin
                $display("FAIL small_%h cyc %0d: q=%b done=%b required q=%b done=%b",
                         word, k, q5, done5, exp_line(k), exp_done(k));
                failures++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5);
        for (int i = 0; i < 5; i++) test_frame(8'($urandom_range(0, 255)));
        test_load_busy();
        test_back_to_back(8'h01, 8'h80);
        test_back_to_back(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        test_reset_mid_frame();
        test_small(5'b10110);
        for (int i = 0; i < 4; i++) test_small(5'($urandom_range(0, 31)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
